// File: rtl/dmem_copy_engine.sv
// Block-copy engine that owns the data-memory port while busy: reads one word,
// writes it to the destination, and accumulates a running 16-bit sum of copied words.
module dmem_copy_engine #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  output logic          memread,
  output logic          memwrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  input  logic [DW-1:0] readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] index_q, index_d;
  logic [LW-1:0] index_inc;
  logic [DW-1:0] buffer_q, buffer_d;
  logic [DW-1:0] checksum_q, checksum_d;
  logic [DW-1:0] writedata_q, writedata_d;
  logic [AW-1:0] address_q, address_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          memread_q, memread_d;
  logic          memwrite_q, memwrite_d;

  // Next-state and datapath; port outputs are decoded from the next state so they
  // are registered yet still track the state they belong to.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    index_d     = index_q;
    buffer_d    = buffer_q;
    checksum_d  = checksum_q;
    index_inc   = index_q + {{(LW-1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = src;
          dst_d      = dst;
          len_d      = len;
          index_d    = {LW{1'b0}};
          checksum_d = {DW{1'b0}};
          state_d    = (len != {LW{1'b0}}) ? READ : DONE;
        end else begin
          state_d    = IDLE;
        end
      end
      READ: begin
        buffer_d   = readdata;
        checksum_d = checksum_q + readdata;
        state_d    = WRITE;
      end
      WRITE: begin
        index_d = index_inc;
        if (index_inc == len_q) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d == READ) || (state_d == WRITE);
    done_d     = (state_d == DONE);
    memread_d  = (state_d == READ);
    memwrite_d = (state_d == WRITE);

    case (state_d)
      READ:    address_d = src_d + AW'(index_d);
      WRITE:   address_d = dst_d + AW'(index_d);
      default: address_d = {AW{1'b0}};
    endcase

    // writedata is only refreshed on entry to WRITE and otherwise holds
    if (state_d == WRITE) begin
      writedata_d = buffer_d;
    end else begin
      writedata_d = writedata_q;
    end
  end

  // State and output registers with immediate reset so a write in flight is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= {AW{1'b0}};
      dst_q       <= {AW{1'b0}};
      len_q       <= {LW{1'b0}};
      index_q     <= {LW{1'b0}};
      buffer_q    <= {DW{1'b0}};
      checksum_q  <= {DW{1'b0}};
      writedata_q <= {DW{1'b0}};
      address_q   <= {AW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      index_q     <= index_d;
      buffer_q    <= buffer_d;
      checksum_q  <= checksum_d;
      writedata_q <= writedata_d;
      address_q   <= address_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign address   = address_q;
  assign writedata = writedata_q;

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Bus initiator that drives the data-memory port (memread, memwrite, address, writedata, readdata) to copy a block of 16-bit words from a source address to a destination address.
- Sits beside the pipeline MEM stage and owns the memory port while busy. The memory samples writes on negedge clk; its readdata is combinational from address gated by memread.
- Also produces a 16-bit running sum of the copied words, used to check the transfer.

Parameters:
- AW, 16, address width (matches memory address port).
- DW, 16, data word width.
- LW, 16, length counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- src  in  AW  source base address; captured with start.
- dst  in  AW  destination base address; captured with start.
- len  in  LW  word count; captured with start.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle pulse in DONE state.
- checksum  out  DW  sum of copied words mod 2^DW; holds until next accepted start.
- memread  out  1  to memory; high only in READ.
- memwrite  out  1  to memory; high only in WRITE.
- address  out  AW  to memory.
- writedata  out  DW  to memory.
- readdata  in  DW  from memory; combinational, valid within the READ cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; busy=0, done=0, memread=0, memwrite=0.
  - address=0, writedata=0, checksum=0; internal index, buffer and captured operands cleared.
  - Reset asserted mid-copy deasserts memwrite before the next negedge, so no write occurs. Words already written remain in memory.
- States: IDLE, READ, WRITE, DONE. Outputs are Moore, decoded from registered state/regs only.
- IDLE:
  - On posedge with start=1: capture src/dst/len, index=0, checksum=0.
  - Next state is READ if len!=0, else DONE.
  - start=0: stay in IDLE. address=0, memread=0, memwrite=0.
- READ:
  - address = src+index (mod 2^AW), memread=1.
  - Posedge: buffer<=readdata, checksum<=checksum+readdata (mod 2^DW); go to WRITE.
- WRITE:
  - address = dst+index (mod 2^AW), memwrite=1, writedata=buffer; the memory commits at the mid-cycle negedge.
  - Posedge: index<=index+1. If index+1==len go to DONE, else go to READ.
- DONE:
  - done=1 for exactly one cycle, busy=0; then IDLE.
  - checksum is final when done=1.
- Latency: a start accepted at edge E gives done high in the cycle after edge E+2*len; len=0 gives done in the cycle after E.
- start while busy or in DONE: ignored, no queueing.
- Address wrap: src+index and dst+index wrap modulo 2^AW. No bounds check against memory depth.
- Overlap: strictly ascending copy with no overlap correction.
  - Word k is read after words 0..k-1 have been written.
  - With dst = src+d (0<d<len), the source pattern repeats with period d.
- writedata holds its last value outside WRITE; the memory ignores it when memwrite=0.
- memread and memwrite are never high in the same cycle.

Test Plan:
- Memory init mem[i]=i. start, src=10, dst=100, len=4 -> mem[100..103]=10,11,12,13; busy high 8 cycles; done one pulse; checksum=46.
- len=0, src=5, dst=50 -> no memread/memwrite ever asserted; done pulses in the cycle after start; checksum=0.
- Overlap: src=20, dst=21, len=3, mem init i -> mem[21..23]=20,20,20; checksum=60.
- Wrap: src=0xFFFE, dst=200, len=3 -> read addresses FFFE, FFFF, 0000 in that order (monitor address/memread); writes to 200..202.
- start pulsed again mid-copy with different operands -> ignored; original transfer completes unchanged; no second done.
- rst asserted during second WRITE of a len=4 copy src=10, dst=100 -> outputs drop immediately; mem[100]=10, mem[102..103] unchanged; engine in IDLE; a fresh start works normally.
